// File: rtl/my_operand_fetch.sv
// Operand-fetch stage: decodes register sources, reads the regfile, forwards
// write-back data, tracks outstanding destinations in a busy scoreboard and
// hands a one-entry operand bundle to the execute unit.
module my_operand_fetch #(
  parameter int unsigned DW      = 16,
  parameter int unsigned AW      = 4,
  parameter logic [3:0]  NOWB_OP = 4'hF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   in_instr,
  output logic [AW-1:0] n1,
  output logic [AW-1:0] n2,
  input  logic [DW-1:0] rd1,
  input  logic [DW-1:0] rd2,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [3:0]    out_op,
  output logic [AW-1:0] out_rd,
  output logic [DW-1:0] out_a,
  output logic [DW-1:0] out_b
);

  localparam int unsigned NREG = 2 ** AW;

  logic [3:0]      op;
  logic [AW-1:0]   rd_f;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic            fwd1;
  logic            fwd2;
  logic            hz1;
  logic            hz2;
  logic            hazard;
  logic            accept;
  logic            issue;
  logic [DW-1:0]   opa;
  logic [DW-1:0]   opb;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;

  // Instruction field decode; read addresses go straight to the regfile.
  always_comb begin
    op   = in_instr[15:12];
    rd_f = AW'(in_instr[11:8]);
    rs1  = AW'(in_instr[7:4]);
    rs2  = AW'(in_instr[3:0]);
  end

  assign n1 = rs1;
  assign n2 = rs2;

  // Source hazards; a source being written back this cycle is forwarded instead.
  always_comb begin
    fwd1   = wb_en && (wb_addr == rs1);
    fwd2   = wb_en && (wb_addr == rs2);
    hz1    = (rs1 != '0) && busy[rs1] && !fwd1;
    hz2    = (rs2 != '0) && busy[rs2] && !fwd2;
    hazard = in_valid && (hz1 || hz2);
  end

  // Operand select: r0 is hard zero, then write-back forward, then regfile.
  always_comb begin
    if (rs1 == '0)  opa = '0;
    else if (fwd1)  opa = wb_data;
    else            opa = rd1;
    if (rs2 == '0)  opb = '0;
    else if (fwd2)  opb = wb_data;
    else            opb = rd2;
  end

  // Handshake: the output slot must be free (or draining) and no hazard pending.
  always_comb begin
    in_ready = (!out_valid || out_ready) && !hazard;
    accept   = in_valid && in_ready;
    issue    = accept && (op != NOWB_OP) && (rd_f != '0);
  end

  // Scoreboard update: write-back clears, issue sets, and set wins on a collision.
  always_comb begin
    busy_next = busy;
    if (wb_en) busy_next[wb_addr] = 1'b0;
    if (issue) busy_next[rd_f]    = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Busy scoreboard register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_next;
  end

  // One-entry output bundle: load on accept, drop valid on a drain-only cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_op    <= '0;
      out_rd    <= '0;
      out_a     <= '0;
      out_b     <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_op    <= op;
      out_rd    <= rd_f;
      out_a     <= opa;
      out_b     <= opb;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_my_operand_fetch.sv
// Self-checking bench for my_operand_fetch: directed scenarios followed by
// randomized traffic, all checked against a transaction-level reference model.
module tb_my_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [3:0]  n1;
  logic [3:0]  n2;
  logic [15:0] rd1;
  logic [15:0] rd2;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_op;
  logic [3:0]  out_rd;
  logic [15:0] out_a;
  logic [15:0] out_b;

  int errors = 0;
  int checks = 0;

  // Regfile contents (the bench plays the regfile) and reference model state.
  logic [15:0] regs [16];
  bit          pend [16];
  bit          m_valid;
  int          m_op, m_rd;
  logic [15:0] m_a, m_b;
  bit          m_wb_en;
  int          m_wb_addr;
  logic [15:0] m_wb_data;

  always #5 clk = ~clk;

  assign rd1 = regs[n1];
  assign rd2 = regs[n2];

  my_operand_fetch dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .n1(n1), .n2(n2), .rd1(rd1), .rd2(rd2),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_rd(out_rd), .out_a(out_a), .out_b(out_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // A source must wait if an earlier instruction will write it and that
  // write is not arriving right now.
  function automatic bit waits_on(input int rs);
    return rs != 0 && pend[rs] && !(m_wb_en && m_wb_addr == rs);
  endfunction

  // Value an instruction sees for a source register at this moment.
  function automatic logic [15:0] value_of(input int rs);
    if (rs == 0) return 16'h0000;
    if (m_wb_en && m_wb_addr == rs) return m_wb_data;
    return regs[rs];
  endfunction

  task automatic model_reset();
    m_valid = 0; m_op = 0; m_rd = 0; m_a = '0; m_b = '0;
    for (int i = 0; i < 16; i++) pend[i] = 0;
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, "_out_valid"}, out_valid, m_valid);
    check({pfx, "_out_op"}, out_op, m_op);
    check({pfx, "_out_rd"}, out_rd, m_rd);
    check({pfx, "_out_a"}, out_a, m_a);
    check({pfx, "_out_b"}, out_b, m_b);
  endtask

  // One clock cycle: drive, check combinational outputs, advance the model, check registers.
  task automatic step(input bit v, input logic [15:0] ins, input bit ordy,
                      input bit we, input logic [3:0] wa, input logic [15:0] wd);
    int op, rdd, rs1, rs2;
    bit hz, rdy, acc;
    logic [15:0] a, b;
    @(negedge clk);
    in_valid = v; in_instr = ins; out_ready = ordy;
    wb_en = we; wb_addr = wa; wb_data = wd;
    m_wb_en = we; m_wb_addr = int'(wa); m_wb_data = wd;
    op = int'(ins[15:12]); rdd = int'(ins[11:8]);
    rs1 = int'(ins[7:4]);  rs2 = int'(ins[3:0]);
    hz  = v && (waits_on(rs1) || waits_on(rs2));
    rdy = (!m_valid || ordy) && !hz;
    acc = v && rdy;
    a = value_of(rs1);
    b = value_of(rs2);
    #1;
    check("in_ready", in_ready, rdy);
    check("n1", n1, rs1);
    check("n2", n2, rs2);
    @(posedge clk);
    #1;
    if (acc) begin
      m_valid = 1; m_op = op; m_rd = rdd; m_a = a; m_b = b;
    end else if (m_valid && ordy) begin
      m_valid = 0;
    end
    if (we) begin
      pend[wa] = 0;
      regs[wa] = wd;
    end
    if (acc && op != 15 && rdd != 0) pend[rdd] = 1;
    check_outputs("cyc");
  endtask

  initial begin
    logic [3:0] wa;
    int cand [$];
    rst = 1'b1; in_valid = 0; in_instr = '0; out_ready = 0;
    wb_en = 0; wb_addr = '0; wb_data = '0;
    m_wb_en = 0; m_wb_addr = 0; m_wb_data = '0;
    for (int i = 0; i < 16; i++) regs[i] = 16'(i * 16'h0111);
    regs[0] = 16'hFFFF; regs[1] = 16'd5; regs[2] = 16'd7;
    model_reset();

    #12;
    check_outputs("reset");
    rst = 1'b0;

    // Plain fetch
    step(1, 16'h3412, 1, 0, 4'h0, 16'h0);
    check("plain_op", out_op, 4'h3);
    check("plain_rd", out_rd, 4'h4);
    check("plain_a", out_a, 16'd5);
    check("plain_b", out_b, 16'd7);

    // Register 0 reads as zero even though the regfile holds FFFF
    step(1, 16'h1500, 1, 0, 4'h0, 16'h0);
    check("zero_a", out_a, 16'h0);
    check("zero_b", out_b, 16'h0);

    // RAW stall on r5, released by a forwarded write-back
    step(1, 16'h1512, 1, 0, 4'h0, 16'h0);
    step(1, 16'h2650, 1, 0, 4'h0, 16'h0);
    check("raw_stall", in_ready, 1'b0);
    step(1, 16'h2650, 1, 0, 4'h0, 16'h0);
    step(1, 16'h2650, 1, 1, 4'h5, 16'h00AA);
    check("raw_fwd_a", out_a, 16'h00AA);
    check("raw_fwd_valid", out_valid, 1'b1);

    // Backpressure: bundle holds, then drains while the next one loads
    for (int i = 0; i < 3; i++) begin
      step(1, 16'h1312, 0, 0, 4'h0, 16'h0);
      check("bp_hold_a", out_a, 16'h00AA);
    end
    step(1, 16'h1312, 1, 0, 4'h0, 16'h0);
    check("bp_next_rd", out_rd, 4'h3);
    check("bp_next_a", out_a, 16'd5);

    // NOWB opcode does not mark its destination busy
    step(0, 16'h0000, 1, 1, 4'h3, 16'h0033);
    step(1, 16'hF312, 1, 0, 4'h0, 16'h0);
    step(1, 16'h1030, 1, 0, 4'h0, 16'h0);
    check("nowb_accept", out_op, 4'h1);
    check("nowb_a", out_a, 16'h0033);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      logic [15:0] ins;
      ins = 16'($urandom);
      if ($urandom_range(0, 3) == 0) ins[15:12] = 4'hF;
      cand.delete();
      for (int i = 1; i < 16; i++) if (pend[i]) cand.push_back(i);
      if (cand.size() != 0 && $urandom_range(0, 1) == 1)
        wa = 4'(cand[$urandom_range(0, cand.size() - 1)]);
      else
        wa = 4'($urandom_range(0, 15));
      step($urandom_range(0, 3) != 0, ins, $urandom_range(0, 3) != 0,
           $urandom_range(0, 1) == 1, wa, 16'($urandom));
    end

    // Reset in the middle of a stall with a bundle held
    step(0, 16'h0000, 1, 1, 4'h9, 16'h0099);
    step(1, 16'h1912, 1, 0, 4'h0, 16'h0);
    step(1, 16'h2790, 0, 0, 4'h0, 16'h0);
    check("mid_stall", in_ready, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_valid", out_valid, 1'b0);
    check("async_a", out_a, 16'h0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    step(1, 16'h2790, 1, 0, 4'h0, 16'h0);
    check("post_reset_valid", out_valid, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
